// File: rtl/flash_loader.sv
// Boot-time copier: reads a fixed-size image from SPI flash with the READ (0x03)
// command and stores it through the ramio write port as little-endian 32-bit words.
module flash_loader #(
   parameter int unsigned TransferByteCount = 256,
   parameter logic [23:0] FlashStartAddress = 24'h00_0000,
   parameter logic [31:0] RamStartAddress   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        flash_clk,
   output logic        flash_mosi,
   input  logic        flash_miso,
   output logic        flash_cs_n,
   output logic        ramio_enable,
   output logic [2:0]  ramio_read_type,
   output logic [1:0]  ramio_write_type,
   output logic [31:0] ramio_address,
   output logic [31:0] ramio_data_in,
   input  logic        ramio_busy
);

   localparam int unsigned CountWidth = $clog2(TransferByteCount) + 1;
   localparam logic [CountWidth-1:0] LastCount = CountWidth'(TransferByteCount);
   localparam logic [CountWidth-1:0] WordBytes = CountWidth'(4);
   localparam logic [7:0] ReadCmd = 8'h03;

   if ((TransferByteCount < 4) || (TransferByteCount % 4 != 0)) begin : g_bad_count
      $error("flash_loader: TransferByteCount must be a multiple of 4 and at least 4");
   end

   typedef enum logic [2:0] {
      IDLE,
      SEND_CMD,
      SEND_ADDR,
      READ_DATA,
      START_WRITE,
      WRITE,
      DONE
   } state_t;

   state_t                state;
   logic                  phase;      // 0: drive flash_clk low + next mosi bit, 1: raise flash_clk
   logic [4:0]            bit_cnt;
   logic [1:0]            byte_idx;
   logic [31:0]           tx_shift;
   logic [6:0]            rx_shift;
   logic [31:0]           word;
   logic [31:0]           word_addr;
   logic [CountWidth-1:0] byte_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the datapath registers are reset as well, so every output leaves reset at a known value.
         state            <= IDLE;
         phase            <= 1'b0;
         bit_cnt          <= '0;
         byte_idx         <= '0;
         tx_shift         <= '0;
         rx_shift         <= '0;
         word             <= '0;
         word_addr        <= '0;
         byte_cnt         <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         flash_clk        <= 1'b0;
         flash_mosi       <= 1'b0;
         flash_cs_n       <= 1'b1;
         ramio_enable     <= 1'b0;
         ramio_read_type  <= 3'b000;
         ramio_write_type <= 2'b00;
         ramio_address    <= '0;
         ramio_data_in    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= SEND_CMD;
                  flash_cs_n <= 1'b0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  word_addr  <= RamStartAddress;
                  byte_cnt   <= '0;
                  phase      <= 1'b0;
                  bit_cnt    <= '0;
                  byte_idx   <= '0;
                  tx_shift   <= {ReadCmd, FlashStartAddress};
               end
            end

            SEND_CMD, SEND_ADDR: begin
               phase <= ~phase;
               if (!phase) begin
                  flash_clk  <= 1'b0;
                  flash_mosi <= tx_shift[31];
                  tx_shift   <= {tx_shift[30:0], 1'b0};
               end else begin
                  flash_clk <= 1'b1;
                  bit_cnt   <= bit_cnt + 5'd1;
                  if (state == SEND_CMD && bit_cnt == 5'd7) begin
                     state <= SEND_ADDR;
                  end
                  if (bit_cnt == 5'd31) begin
                     state   <= READ_DATA;
                     bit_cnt <= '0;
                  end
               end
            end

            READ_DATA: begin
               phase <= ~phase;
               if (!phase) begin
                  flash_clk  <= 1'b0;
                  flash_mosi <= 1'b0;
               end else begin
                  // flash_miso is captured on the same edge that raises flash_clk
                  flash_clk <= 1'b1;
                  bit_cnt   <= bit_cnt + 5'd1;
                  if (bit_cnt[2:0] == 3'd7) begin
                     word[{byte_idx, 3'b000} +: 8] <= {rx_shift, flash_miso};
                     byte_idx                      <= byte_idx + 2'd1;
                     bit_cnt                       <= '0;
                     if (byte_idx == 2'd3) begin
                        state <= START_WRITE;
                     end
                  end else begin
                     rx_shift <= {rx_shift[5:0], flash_miso};
                  end
               end
            end

            START_WRITE: begin
               flash_clk <= 1'b0;
               if (!ramio_busy) begin
                  ramio_enable     <= 1'b1;
                  ramio_write_type <= 2'b11;
                  ramio_address    <= word_addr;
                  ramio_data_in    <= word;
                  word_addr        <= word_addr + 32'd4;
                  byte_cnt         <= byte_cnt + WordBytes;
                  state            <= WRITE;
               end
            end

            WRITE: begin
               if (!ramio_busy) begin
                  ramio_enable     <= 1'b0;
                  ramio_write_type <= 2'b00;
                  if (byte_cnt < LastCount) begin
                     // chip select stays low so the flash keeps streaming from where it paused
                     state <= READ_DATA;
                     phase <= 1'b0;
                  end else begin
                     state      <= DONE;
                     flash_cs_n <= 1'b1;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
Boot-time sequencer that copies a fixed-size image from the SPI flash into RAM through the ramio write port. It issues a flash READ (0x03) command and a 24-bit address, shifts bytes in, and packs each 4 bytes into a little-endian word. Each word is written to ramio as a full-word store, and the block signals completion. It sits between the flash pins and the ramio request port and owns ramio only while busy; the core is held off until done.

Parameters:
TransferByteCount, 256, bytes copied; must be a multiple of 4 and >= 4; elaboration $error otherwise
FlashStartAddress, 0, 24-bit flash byte address of the image
RamStartAddress, 0, 32-bit ramio byte address of the first word

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin a transfer; sampled only in Idle
busy  out  1  high from the cycle after start is accepted until Done
done  out  1  high in Done; held until the next accepted start or rst
flash_clk  out  1  SPI clock = clk/2 while active, idles 0
flash_mosi  out  1  SPI data to flash
flash_miso  in  1  SPI data from flash
flash_cs_n  out  1  flash chip select, active-low
ramio_enable  out  1  ramio request
ramio_read_type  out  3  always 0
ramio_write_type  out  2  2'b11 while requesting, else 0
ramio_address  out  32  ramio byte address
ramio_data_in  out  32  word to write
ramio_busy  in  1  ramio busy

Behaviour:
- Reset (async, any state): flash_cs_n=1, flash_clk=0, flash_mosi=0, ramio_enable=0, ramio_write_type=0, ramio_read_type=0, ramio_address=0, ramio_data_in=0, busy=0, done=0; state=Idle. A reset mid-transfer abandons the transfer; a partially written image is not cleaned up.
- States: Idle, SendCmd, SendAddr, ReadData, StartWrite, Write, Done.
- Idle: on start=1, the next state is SendCmd. That cycle sets flash_cs_n=0, busy=1, done=0, and word address = RamStartAddress.
- SPI bit timing is 2 clk per bit, mode 0. Phase A drives flash_clk=0 and flash_mosi=next bit, MSB first. Phase B drives flash_clk=1.
- SendCmd sends 8 bits of 0x03, then goes to SendAddr. SendAddr sends 24 bits of FlashStartAddress, then goes to ReadData. The first flash_clk rise comes 2 cycles after start is accepted, and the command plus address take 64 cycles.
- ReadData: flash_mosi=0. flash_miso is shifted in on the clk edge that drives flash_clk 0->1. Every 16 cycles (8 bits) a byte completes. Byte n of the group goes to word bits [8n+7:8n], n=0..3. After the 4th byte the next state is StartWrite, and flash_clk stays 0 while stalled.
- StartWrite: waits for ramio_busy=0. It then drives ramio_enable=1, write_type=2'b11, read_type=0, address=current word address, and data_in=packed word. The word address advances by 4, and the next state is Write.
- Write: ramio_busy is evaluated from the cycle after enable rises. On the first cycle with ramio_busy=0 it drops ramio_enable and write_type. If bytes written < TransferByteCount it returns to ReadData, resuming the SPI clock with flash_cs_n still 0. Otherwise it goes to Done with flash_cs_n=1.
- Done: busy=0, done=1. start=1 here is treated like Idle and restarts the transfer.
- start while busy is ignored.
- Flash is read as one continuous burst. cs_n stays low across ramio stalls, so the flash address auto-increments.
- Word/byte counters: width clog2(TransferByteCount)+1; no wrap.
- Outputs are registered; no combinational path from ramio_busy or flash_miso to any output.

Test Plan:
- Flash model with ram.mem, defaults, ramio+sdram behind, pulse start -> flash_cs_n falls 1 cycle later; first 8 flash_clk rises carry mosi 0,0,0,0,0,0,1,1 and the next 24 carry 0; done=1 after 64 words; ramio read of byte address 16 returns 32'hD5B8A9C4.
- Stub ramio holding ramio_busy=1 for 7 cycles after each enable -> ramio_enable stays high for the whole busy window; flash_clk is frozen at 0 and cs_n stays 0 during the stall; all 64 words land at addresses 0,4,...,252 with correct data.
- FlashStartAddress=16, RamStartAddress=32'h100, TransferByteCount=4 -> exactly one ramio write, address 32'h100, data 32'hD5B8A9C4; done=1; flash_cs_n=1.
- Assert rst during the 10th word's ReadData -> same cycle: flash_cs_n=1, ramio_enable=0, busy=0, done=0; a new start reruns the full transfer correctly.
- start pulsed while busy=1 -> no effect and the total write count stays 64; start in Done -> done drops and a second identical transfer completes.
